// File: rtl/spectrum_renderer.sv
// Spectrum-bar pixel source for vga_driver: mirrors the driver's raster position and
// registers one colour per clock from a tear-free display copy of the bar heights.
`timescale 1ns/1ps
module spectrum_renderer #(
    parameter int          HPX      = 1024,
    parameter int          VLN      = 600,
    parameter int          NBARS    = 32,
    parameter int          BAR_W    = 32,
    parameter int          GAP      = 4,
    parameter int          DECAY    = 4,
    parameter logic [23:0] BAR_RGB  = 24'h00C040,
    parameter logic [23:0] PEAK_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_col,
    input  logic                     new_row,
    input  logic                     new_frame,
    input  logic                     bar_we,
    input  logic [$clog2(NBARS)-1:0] bar_addr,
    input  logic [9:0]               bar_height,
    output logic [23:0]              color,
    output logic                     frame_tick
);
    localparam int AW  = $clog2(NBARS);
    localparam int AW1 = AW + 1;
    localparam int DW  = (DECAY > 1) ? $clog2(DECAY) : 1;

    logic [10:0]   x;
    logic [9:0]    y;
    logic [9:0]    stage [NBARS];
    logic [9:0]    disp  [NBARS];
    logic [9:0]    peak  [NBARS];
    logic [DW-1:0] dcnt  [NBARS];

    logic          addr_ok;
    logic [9:0]    clamped;

    // With a power-of-two bar count every address is in range.
    generate
        if (NBARS == (1 << AW)) begin : g_full_addr
            assign addr_ok = 1'b1;
        end else begin : g_part_addr
            assign addr_ok = ({1'b0, bar_addr} < AW1'(NBARS));
        end
    endgenerate

    assign clamped = (bar_height > 10'(VLN)) ? 10'(VLN) : bar_height;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            if (new_col) x <= new_row ? '0 : x + 11'd1;
            if (new_row) y <= new_frame ? '0 : y + 10'd1;
        end
    end

    // Swap reads stage before the same-cycle write lands, so a write on the
    // new_frame cycle is only shown one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBARS; i++) begin
                stage[i] <= '0;
                disp[i]  <= '0;
                peak[i]  <= '0;
                dcnt[i]  <= '0;
            end
        end else begin
            if (new_frame) begin
                for (int i = 0; i < NBARS; i++) begin
                    disp[i] <= stage[i];
                    if (stage[i] >= peak[i]) begin
                        peak[i] <= stage[i];
                        dcnt[i] <= '0;
                    end else if (dcnt[i] == DW'(DECAY - 1)) begin
                        peak[i] <= ((peak[i] - 10'd1) < stage[i]) ? stage[i] : peak[i] - 10'd1;
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end
            end
            if (bar_we && addr_ok) stage[bar_addr] <= clamped;
        end
    end

    logic [10:0]   b;
    logic [10:0]   c;
    logic [AW-1:0] bi;
    logic [9:0]    pk;
    logic [9:0]    dh;
    logic [23:0]   pix;

    // Row tests use y + height so the peak row of a full-height bar (row -1) never matches.
    always_comb begin
        b   = x / 11'(BAR_W);
        c   = x % 11'(BAR_W);
        bi  = b[AW-1:0];
        pk  = peak[bi];
        dh  = disp[bi];
        pix = BG_RGB;
        if (x >= 11'(HPX) || y >= 10'(VLN) || b >= 11'(NBARS) || c >= 11'(BAR_W - GAP)) begin
            pix = BG_RGB;
        end else if (pk != '0 && ({1'b0, y} + {1'b0, pk}) == 11'(VLN - 1)) begin
            pix = PEAK_RGB;
        end else if (({1'b0, y} + {1'b0, dh}) >= 11'(VLN)) begin
            pix = BAR_RGB;
        end else begin
            pix = BG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color      <= BG_RGB;
            frame_tick <= 1'b0;
        end else begin
            color      <= pix;
            frame_tick <= new_frame;
        end
    end

endmodule
